keypad_encoder: RTL and testbench



---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_encoder_if.sv | 14 +
 rtl/keypad_sync.sv | 23 ++
 rtl/keypad_encoder.sv | 131 +++++++++++++
 tb/tb_keypad_encoder.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad front end: FSM states, decode
// result codes and the key-line decoder.
package keypad_pkg;

  localparam int NUM_KEYS = 10;

  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam logic [3:0] KEY_MULTI = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESS,
    WAIT_RELEASE
  } kp_state_t;

  // Single key -> its index; no key -> KEY_NONE; two or more -> KEY_MULTI.
  function automatic logic [3:0] decode_keys(input logic [NUM_KEYS-1:0] keys);
    logic [3:0] code;
    int         hits;
    code = KEY_NONE;
    hits = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) begin
        hits++;
        code = 4'(i);
      end
    end
    if (hits > 1) code = KEY_MULTI;
    return code;
  endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// Keypad encoder bus: raw key lines and lock in, BCD digit and load strobe out.
// The encoder takes the slave side; the keypad/timer environment is master.
interface keypad_encoder_if;
  import keypad_pkg::*;

  logic [NUM_KEYS-1:0] keypad;
  logic                lock;
  logic [3:0]          number;
  logic                loadn;
  logic                key_held;

  modport master (output keypad, lock, input number, loadn, key_held);
  modport slave  (input keypad, lock, output number, loadn, key_held);
endinterface

// File: rtl/keypad_sync.sv
// Generic N-bit two-flop synchroniser with asynchronous active-low clear.
module keypad_sync #(
  parameter int N = 1
) (
  input  logic         clock,
  input  logic         clearn,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta;

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// Keypad encoder: sync, debounce, multi-key reject, one loadn strobe per press.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
//
// state        | meaning
// IDLE         | no key accepted, waiting for a single clean key
// DEBOUNCE     | counting consecutive stable samples of code_reg
// PRESS        | press accepted, strobe issued on the following cycle
// WAIT_RELEASE | waiting for DEBOUNCE_CYCLES consecutive no-key samples
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 16
`endif
) (
  input  logic             clock,
  input  logic             clearn,
  keypad_encoder_if.slave  bus
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] ks;
  logic [3:0]          ks_code;
  logic                ks_valid;

  kp_state_t  state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [3:0] code_reg, code_next;
  logic       rep_fire;
  logic       strobe;

  keypad_sync #(.N(NUM_KEYS)) u_sync (
    .clock  (clock),
    .clearn (clearn),
    .d      (bus.keypad),
    .q      (ks)
  );

  assign ks_code  = decode_keys(ks);
  assign ks_valid = (ks_code != KEY_NONE) && (ks_code != KEY_MULTI);

  // cnt doubles as the press-debounce and release-debounce counter
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    code_next  = code_reg;
    case (state)
      IDLE: begin
        if (!bus.lock && ks_valid) begin
          code_next  = ks_code;
          cnt_next   = 8'd1;
          state_next = (DEBOUNCE_CYCLES == 1) ? PRESS : DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (bus.lock) begin
          state_next = WAIT_RELEASE;
          cnt_next   = '0;
        end else if (ks_code == code_reg) begin
          if (cnt >= DB_LAST) state_next = PRESS;
          else                cnt_next   = cnt + 8'd1;
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      PRESS: begin
        state_next = WAIT_RELEASE;
        cnt_next   = '0;
      end
      WAIT_RELEASE: begin
        if (ks_code == KEY_NONE) begin
          if (cnt >= DB_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end else begin
          cnt_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [9:0] REP_LAST = 10'(REPEAT_CYCLES);

  logic [9:0] rep_cnt;
  logic       rep_hold;

  assign rep_hold = (state == WAIT_RELEASE) && !bus.lock && (ks_code == code_reg);
  assign rep_fire = rep_hold && (rep_cnt == REP_LAST);

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn)                  rep_cnt <= '0;
    else if (!rep_hold || rep_fire) rep_cnt <= '0;
    else                          rep_cnt <= rep_cnt + 10'd1;
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign strobe = (state == PRESS) || rep_fire;

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state        <= IDLE;
      cnt          <= '0;
      code_reg     <= '0;
      bus.number   <= '0;
      bus.loadn    <= 1'b1;
      bus.key_held <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      code_reg     <= code_next;
      bus.loadn    <= !strobe;
      bus.key_held <= (state_next != IDLE);
      if (strobe) bus.number <= code_reg;
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder (DEBOUNCE_CYCLES=4 main instance, =1 boundary).
module tb_keypad_encoder;

  logic clock = 1'b0;
  logic clearn = 1'b0;
  always #5 clock = ~clock;

  keypad_encoder_if bus ();
  keypad_encoder_if bus1 ();

  keypad_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clock  (clock),
    .clearn (clearn),
    .bus    (bus)
  );

  keypad_encoder #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clock  (clock),
    .clearn (clearn),
    .bus    (bus1)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobes = 0;
  int strobe_cyc = 0;
  logic [3:0] strobe_num = 4'd0;

  // cyc = number of rising edges seen; loadn is sampled 1 time unit after each
  always @(posedge clock) begin
    #1;
    cyc++;
    if (bus.loadn === 1'b0) begin
      strobes++;
      strobe_cyc = cyc;
      strobe_num = bus.number;
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    int c;
    bus.keypad = '0; bus.lock = 1'b0;
    bus1.keypad = '0; bus1.lock = 1'b0;
    clearn = 1'b0;
    hold(2);
    clearn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      vectors++;
      if (bus.number !== 4'd0 || bus.loadn !== 1'b1 || bus.key_held !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d: got number=%0d loadn=%b held=%b want 0/1/0",
                 i, bus.number, bus.loadn, bus.key_held);
      end
    end
    c = cyc;
    bus.keypad = 10'(1 << 6);
    wait_cyc(c + 7);
    vectors++;
    if (bus.loadn !== 1'b0 || bus.number !== 4'd6) begin
      miscompares++;
      $display("FAIL reset_pre_strobe: got loadn=%b number=%0d want 0/6", bus.loadn, bus.number);
    end
    #2 clearn = 1'b0;
    #1;
    vectors++;
    if (bus.number !== 4'd0 || bus.loadn !== 1'b1 || bus.key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: got number=%0d loadn=%b held=%b want 0/1/0",
               bus.number, bus.loadn, bus.key_held);
    end
    bus.keypad = '0;
    hold(3);
    clearn = 1'b1;
    hold(2);
  endtask

  task automatic test_clean_press();
    int c, r, s0;
    s0 = strobes;
    c = cyc;
    bus.keypad = 10'(1 << 7);
    wait_cyc(c + 6);
    vectors++;
    if (bus.loadn !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_early: got loadn=%b want 1", bus.loadn);
    end
    wait_cyc(c + 7);
    vectors++;
    if (bus.loadn !== 1'b0 || bus.number !== 4'd7) begin
      miscompares++;
      $display("FAIL clean_strobe: got loadn=%b number=%0d want 0/7", bus.loadn, bus.number);
    end
    wait_cyc(c + 20);
    vectors++;
    if (strobes != s0 + 1 || strobe_cyc != c + 7 || bus.number !== 4'd7) begin
      miscompares++;
      $display("FAIL clean_single: got strobes=%0d at=%0d number=%0d want %0d/%0d/7",
               strobes - s0, strobe_cyc, bus.number, 1, c + 7);
    end
    r = cyc;
    bus.keypad = '0;
    wait_cyc(r + 5);
    vectors++;
    if (bus.key_held !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_release_hold: got held=%b want 1", bus.key_held);
    end
    wait_cyc(r + 6);
    vectors++;
    if (bus.key_held !== 1'b0 || strobes != s0 + 1) begin
      miscompares++;
      $display("FAIL clean_release: got held=%b strobes=%0d want 0/1", bus.key_held, strobes - s0);
    end
    hold(2);
  endtask

  task automatic test_bounce();
    int c, s0;
    s0 = strobes;
    for (int i = 0; i < 5; i++) begin
      bus.keypad = 10'(1 << 3);
      hold(2);
      bus.keypad = '0;
      hold(1);
    end
    c = cyc;
    bus.keypad = 10'(1 << 3);
    wait_cyc(c + 6);
    vectors++;
    if (strobes != s0) begin
      miscompares++;
      $display("FAIL bounce_quiet: got strobes=%0d want 0", strobes - s0);
    end
    wait_cyc(c + 12);
    vectors++;
    if (strobes != s0 + 1 || strobe_cyc != c + 7 || strobe_num !== 4'd3) begin
      miscompares++;
      $display("FAIL bounce_accept: got strobes=%0d at=%0d num=%0d want 1/%0d/3",
               strobes - s0, strobe_cyc, strobe_num, c + 7);
    end
    bus.keypad = '0;
    hold(8);
  endtask

  task automatic test_multi();
    int c, r, s0;
    s0 = strobes;
    bus.keypad = 10'((1 << 2) | (1 << 5));
    hold(15);
    vectors++;
    if (strobes != s0 || bus.number !== 4'd3 || bus.key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_reject: got strobes=%0d number=%0d held=%b want 0/3/0",
               strobes - s0, bus.number, bus.key_held);
    end
    bus.keypad = '0;
    hold(8);
    c = cyc;
    bus.keypad = 10'(1 << 2);
    wait_cyc(c + 10);
    bus.keypad = bus.keypad | 10'(1 << 5);
    wait_cyc(c + 20);
    vectors++;
    if (strobes != s0 + 1 || strobe_num !== 4'd2 || bus.number !== 4'd2 || bus.key_held !== 1'b1) begin
      miscompares++;
      $display("FAIL multi_added: got strobes=%0d num=%0d held=%b want 1/2/1",
               strobes - s0, bus.number, bus.key_held);
    end
    r = cyc;
    bus.keypad = '0;
    wait_cyc(r + 5);
    vectors++;
    if (bus.key_held !== 1'b1) begin
      miscompares++;
      $display("FAIL multi_release_hold: got held=%b want 1", bus.key_held);
    end
    wait_cyc(r + 6);
    vectors++;
    if (bus.key_held !== 1'b0 || strobes != s0 + 1) begin
      miscompares++;
      $display("FAIL multi_release: got held=%b strobes=%0d want 0/1", bus.key_held, strobes - s0);
    end
    hold(2);
  endtask

  task automatic test_lock();
    int c, r, s0;
    s0 = strobes;
    c = cyc;
    bus.keypad = 10'(1 << 9);
    wait_cyc(c + 3);
    bus.lock = 1'b1;
    wait_cyc(c + 18);
    vectors++;
    if (strobes != s0 || bus.key_held !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_mid_press: got strobes=%0d held=%b want 0/1", strobes - s0, bus.key_held);
    end
    bus.lock = 1'b0;
    wait_cyc(c + 28);
    vectors++;
    if (strobes != s0 || bus.key_held !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_drop_held: got strobes=%0d held=%b want 0/1", strobes - s0, bus.key_held);
    end
    r = cyc;
    bus.keypad = '0;
    wait_cyc(r + 6);
    vectors++;
    if (bus.key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_release: got held=%b want 0", bus.key_held);
    end
    bus.lock = 1'b1;
    bus.keypad = 10'(1 << 8);
    hold(12);
    vectors++;
    if (strobes != s0 || bus.key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_idle: got strobes=%0d held=%b want 0/0", strobes - s0, bus.key_held);
    end
    bus.keypad = '0;
    hold(4);
    bus.lock = 1'b0;
    hold(2);
    c = cyc;
    bus.keypad = 10'(1 << 1);
    wait_cyc(c + 12);
    vectors++;
    if (strobes != s0 + 1 || strobe_cyc != c + 7 || bus.number !== 4'd1) begin
      miscompares++;
      $display("FAIL lock_after: got strobes=%0d at=%0d number=%0d want 1/%0d/1",
               strobes - s0, strobe_cyc, bus.number, c + 7);
    end
    bus.keypad = '0;
    hold(8);
  endtask

  task automatic test_sequence();
    int c, s0;
    logic [3:0] keys [3];
    keys[0] = 4'd1; keys[1] = 4'd3; keys[2] = 4'd0;
    for (int k = 0; k < 3; k++) begin
      s0 = strobes;
      c = cyc;
      bus.keypad = 10'(1 << keys[k]);
      wait_cyc(c + 10);
      vectors++;
      if (strobes != s0 + 1 || strobe_cyc != c + 7 || strobe_num !== keys[k]) begin
        miscompares++;
        $display("FAIL sequence_%0d: got strobes=%0d at=%0d num=%0d want 1/%0d/%0d",
                 k, strobes - s0, strobe_cyc, strobe_num, c + 7, keys[k]);
      end
      bus.keypad = '0;
      hold(8);
    end
  endtask

  task automatic test_autorepeat();
    int c, t, s0, n_exp, last_exp;
    s0 = strobes;
    c = cyc;
    t = c + 7;
    bus.keypad = 10'(1 << 4);
    wait_cyc(t + 60);
`ifdef KEYPAD_AUTOREPEAT_EN
    n_exp = 4;
    last_exp = t + 51;
`else
    n_exp = 1;
    last_exp = t;
`endif
    vectors++;
    if (strobes - s0 != n_exp || strobe_cyc != last_exp || bus.number !== 4'd4) begin
      miscompares++;
      $display("FAIL autorepeat: got strobes=%0d last=%0d number=%0d want %0d/%0d/4",
               strobes - s0, strobe_cyc, bus.number, n_exp, last_exp);
    end
    bus.keypad = '0;
    hold(8);
  endtask

  task automatic test_min_debounce();
    int c;
    c = cyc;
    bus1.keypad = 10'(1 << 5);
    wait_cyc(c + 3);
    vectors++;
    if (bus1.loadn !== 1'b1) begin
      miscompares++;
      $display("FAIL min_db_early: got loadn=%b want 1", bus1.loadn);
    end
    wait_cyc(c + 4);
    vectors++;
    if (bus1.loadn !== 1'b0 || bus1.number !== 4'd5) begin
      miscompares++;
      $display("FAIL min_db_strobe: got loadn=%b number=%0d want 0/5", bus1.loadn, bus1.number);
    end
    wait_cyc(c + 5);
    vectors++;
    if (bus1.loadn !== 1'b1) begin
      miscompares++;
      $display("FAIL min_db_one_cycle: got loadn=%b want 1", bus1.loadn);
    end
    bus1.keypad = '0;
    hold(6);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_lock();
    test_sequence();
    test_autorepeat();
    test_min_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
